// File: rtl/alut_addr_checker_gen_if.sv
// Bus bundle for the ALUT address checker: command handshake, result and table-memory port.
// The slave modport is the checker's view; master is the requester/memory side.
interface alut_addr_checker_gen_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 48,
  parameter int HASH_W    = 8,
  parameter int TIME_W    = 32
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int EW     = 1 + TIME_W + PORT_W + ADDR_W;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_W-1:0]    d_addr;
  logic [ADDR_W-1:0]    s_addr;
  logic [PORT_W-1:0]    s_port;
  logic [ADDR_W-1:0]    mac_addr;
  logic [TIME_W-1:0]    curr_time;
  logic [TIME_W-1:0]    max_age;
  logic                 clear_reused;
  logic                 done;
  logic [NUM_PORTS:0]   d_port;
  logic                 busy;
  logic [HASH_W-1:0]    mem_addr;
  logic                 mem_rd;
  logic                 mem_wr;
  logic [EW-1:0]        mem_wdata;
  logic [EW-1:0]        mem_rdata;
  logic                 reused;
  logic [ADDR_W-1:0]    lst_inv_addr;
  logic [PORT_W-1:0]    lst_inv_port;

  modport slave (
    input  cmd_valid, d_addr, s_addr, s_port, mac_addr, curr_time, max_age,
           clear_reused, mem_rdata,
    output cmd_ready, done, d_port, busy, mem_addr, mem_rd, mem_wr, mem_wdata,
           reused, lst_inv_addr, lst_inv_port
  );

  modport master (
    output cmd_valid, d_addr, s_addr, s_port, mac_addr, curr_time, max_age,
           clear_reused, mem_rdata,
    input  cmd_ready, done, d_port, busy, mem_addr, mem_rd, mem_wr, mem_wdata,
           reused, lst_inv_addr, lst_inv_port
  );
endinterface

// File: rtl/alut_addr_checker_gen.sv
// ALUT address checker: destination lookup, source learning and reuse detection over a hashed table.
// Optional macro BCAST_FILTER_EN floods broadcast destinations without a table lookup.
module alut_addr_checker_gen #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 48,
  parameter int HASH_W    = 8,
  parameter int TIME_W    = 32
) (
  input logic pclk,
  input logic p_reset,
  alut_addr_checker_gen_if.slave bus
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int EW     = 1 + TIME_W + PORT_W + ADDR_W;
  localparam int NCH    = (ADDR_W + HASH_W - 1) / HASH_W;

  typedef enum logic [2:0] {
    IDLE, MAC_CHK, RD_DEST, DEST_EVAL, RD_SRC, SRC_EVAL, WR_SRC, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    dAddr_q, dAddr_d;
  logic [ADDR_W-1:0]    sAddr_q, sAddr_d;
  logic [PORT_W-1:0]    sPort_q, sPort_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [NUM_PORTS:0]   dPort_q, dPort_d;
  logic                 done_q, done_d;
  logic                 reused_q, reused_d;
  logic [ADDR_W-1:0]    lstInvAddr_q, lstInvAddr_d;
  logic [PORT_W-1:0]    lstInvPort_q, lstInvPort_d;

  logic                 accept;
  logic                 entValid;
  logic [TIME_W-1:0]    entTime;
  logic [PORT_W-1:0]    entPort;
  logic [ADDR_W-1:0]    entAddr;
  logic [TIME_W-1:0]    entAge;
  logic                 hit;

  // XOR-fold of the address; the top chunk is zero-extended when widths do not divide evenly
  function automatic logic [HASH_W-1:0] hashAddr(input logic [ADDR_W-1:0] a);
    logic [NCH*HASH_W-1:0] ext;
    logic [HASH_W-1:0]     h;
    ext = '0;
    ext[ADDR_W-1:0] = a;
    h = '0;
    for (int i = 0; i < NCH; i++) begin
      h = h ^ ext[i*HASH_W +: HASH_W];
    end
    return h;
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(input logic [PORT_W-1:0] p);
    logic [NUM_PORTS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      v[i] = (int'(p) == i);
    end
    return v;
  endfunction

  assign accept   = bus.cmd_valid && (state_q == IDLE);
  assign entValid = bus.mem_rdata[EW-1];
  assign entTime  = bus.mem_rdata[ADDR_W+PORT_W +: TIME_W];
  assign entPort  = bus.mem_rdata[ADDR_W +: PORT_W];
  assign entAddr  = bus.mem_rdata[ADDR_W-1:0];
  // Modulo subtraction keeps the age correct across timestamp wrap-around
  assign entAge   = time_q - entTime;
  assign hit      = entValid && (entAddr == dAddr_q) && (entAge <= bus.max_age);

  always_comb begin
    state_d      = state_q;
    dAddr_d      = dAddr_q;
    sAddr_d      = sAddr_q;
    sPort_d      = sPort_q;
    time_d       = time_q;
    dPort_d      = dPort_q;
    done_d       = (state_q == DONE);
    reused_d     = reused_q;
    lstInvAddr_d = lstInvAddr_q;
    lstInvPort_d = lstInvPort_q;

    if (bus.clear_reused) begin
      reused_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          dAddr_d = bus.d_addr;
          sAddr_d = bus.s_addr;
          sPort_d = bus.s_port;
          time_d  = bus.curr_time;
          state_d = MAC_CHK;
        end
      end
      MAC_CHK: begin
        if (dAddr_q == bus.mac_addr) begin
          dPort_d = {1'b1, {NUM_PORTS{1'b0}}};
          state_d = DONE;
        end
`ifdef BCAST_FILTER_EN
        else if (&dAddr_q) begin
          dPort_d = {1'b0, ~onehot(sPort_q)};
          state_d = RD_SRC;
        end
`endif
        else begin
          state_d = RD_DEST;
        end
      end
      RD_DEST: state_d = DEST_EVAL;
      DEST_EVAL: begin
        if (hit) begin
          dPort_d = {1'b0, onehot(entPort) & ~onehot(sPort_q)};
        end else begin
          dPort_d = {1'b0, ~onehot(sPort_q)};
        end
        state_d = RD_SRC;
      end
      RD_SRC: state_d = SRC_EVAL;
      SRC_EVAL: begin
        if (entValid && (entAddr != sAddr_q)) begin
          reused_d     = 1'b1;
          lstInvAddr_d = entAddr;
          lstInvPort_d = entPort;
        end
        state_d = WR_SRC;
      end
      WR_SRC: state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_q      <= IDLE;
      dAddr_q      <= '0;
      sAddr_q      <= '0;
      sPort_q      <= '0;
      time_q       <= '0;
      dPort_q      <= {1'b0, {NUM_PORTS{1'b1}}};
      done_q       <= 1'b0;
      reused_q     <= 1'b0;
      lstInvAddr_q <= '0;
      lstInvPort_q <= '0;
    end else begin
      state_q      <= state_d;
      dAddr_q      <= dAddr_d;
      sAddr_q      <= sAddr_d;
      sPort_q      <= sPort_d;
      time_q       <= time_d;
      dPort_q      <= dPort_d;
      done_q       <= done_d;
      reused_q     <= reused_d;
      lstInvAddr_q <= lstInvAddr_d;
      lstInvPort_q <= lstInvPort_d;
    end
  end

  // Memory strobes decode straight from the state so reset drops them immediately
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      RD_DEST: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = hashAddr(dAddr_q);
      end
      RD_SRC: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = hashAddr(sAddr_q);
      end
      WR_SRC: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = hashAddr(sAddr_q);
        bus.mem_wdata = {1'b1, time_q, sPort_q, sAddr_q};
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.d_port       = dPort_q;
  assign bus.reused       = reused_q;
  assign bus.lst_inv_addr = lstInvAddr_q;
  assign bus.lst_inv_port = lstInvPort_q;
endmodule

// File: tb/tb_alut_addr_checker_gen.sv
// Directed bench for alut_addr_checker_gen with a behavioural table memory.
// Addresses are chosen so their XOR-fold hashes are obvious by inspection.
module tb_alut_addr_checker_gen;
  localparam int NP = 4;
  localparam int AW = 48;
  localparam int HW = 8;
  localparam int TW = 32;
  localparam int PW = 2;
  localparam int EW = 1 + TW + PW + AW;

  localparam logic [AW-1:0] MAC = 48'h0A0B0C0D0E0F;
  localparam logic [AW-1:0] D1  = 48'h0000_0000_0001;
  localparam logic [AW-1:0] S1  = 48'h0000_0000_0002;
  localparam logic [AW-1:0] AA  = 48'h0000_0000_0011;
  localparam logic [AW-1:0] CC  = 48'h0000_0000_0022;
  localparam logic [AW-1:0] A2  = 48'h0000_0000_0066;
  localparam logic [AW-1:0] B2  = 48'h0000_0000_6600;

  logic pclk = 1'b0;
  logic p_reset;
  int   errors = 0;
  int   checks = 0;
  logic bothHigh = 1'b0;

  always #5 pclk = ~pclk;

  alut_addr_checker_gen_if #(.NUM_PORTS(NP), .ADDR_W(AW), .HASH_W(HW), .TIME_W(TW)) bus ();

  alut_addr_checker_gen #(.NUM_PORTS(NP), .ADDR_W(AW), .HASH_W(HW), .TIME_W(TW)) dut (
    .pclk    (pclk),
    .p_reset (p_reset),
    .bus     (bus)
  );

  logic [EW-1:0] mem [256];
  logic          preWr = 1'b0;
  logic [HW-1:0] preAddr = '0;
  logic [EW-1:0] preData = '0;

  // Table memory with one-cycle read latency; the bench can also preload entries
  always @(posedge pclk) begin
    if (preWr) mem[preAddr] <= preData;
    else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge pclk) begin
    if (bus.mem_rd && bus.mem_wr) bothHigh = 1'b1;
  end

  function automatic logic [EW-1:0] entry(input logic [TW-1:0] t, input logic [PW-1:0] p,
                                          input logic [AW-1:0] a);
    return {1'b1, t, p, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [HW-1:0] a, input logic [EW-1:0] d);
    @(negedge pclk);
    preWr = 1'b1; preAddr = a; preData = d;
    @(negedge pclk);
    preWr = 1'b0;
  endtask

  // Issues one command, scrambles the inputs after acceptance and counts cycles to done
  task automatic applyStimulus(input logic [AW-1:0] d, input logic [AW-1:0] s,
                               input logic [PW-1:0] sp, input logic [TW-1:0] t,
                               input int clrAt, input int stopAt,
                               output int lat, output logic sawWr);
    @(negedge pclk);
    bus.cmd_valid = 1'b1; bus.d_addr = d; bus.s_addr = s; bus.s_port = sp; bus.curr_time = t;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0; bus.d_addr = ~d; bus.s_addr = ~s; bus.s_port = sp + 2'd1;
    bus.curr_time = t + 32'd999;
    lat = 0;
    sawWr = 1'b0;
    while (lat < 20) begin
      @(posedge pclk);
      #1;
      lat++;
      if (bus.mem_wr) sawWr = 1'b1;
      bus.clear_reused = (lat == clrAt);
      if (bus.done || lat == stopAt) break;
    end
    bus.clear_reused = 1'b0;
  endtask

  initial begin
    int   lat;
    logic sawWr;
`ifdef BCAST_FILTER_EN
    int   bcastLat = 5;
`else
    int   bcastLat = 7;
`endif
    bus.cmd_valid = 1'b0; bus.d_addr = '0; bus.s_addr = '0; bus.s_port = '0;
    bus.mac_addr = MAC; bus.curr_time = '0; bus.max_age = 32'd60; bus.clear_reused = 1'b0;
    p_reset = 1'b1;
    for (int i = 0; i < 256; i++) preload(8'(i), '0);
    @(negedge pclk);
    checkOutput("rst.dport", bus.d_port, 5'b0_1111);
    checkOutput("rst.done", bus.done, 1'b0);
    checkOutput("rst.busy", bus.busy, 1'b0);
    checkOutput("rst.ready", bus.cmd_ready, 1'b1);
    checkOutput("rst.memctl", {bus.mem_rd, bus.mem_wr, bus.mem_addr}, '0);
    p_reset = 1'b0;

    applyStimulus(MAC, 48'h77, 2'd1, 32'd5, -1, -1, lat, sawWr);
    checkOutput("mac.dport", bus.d_port, 5'b1_0000);
    checkOutput("mac.lat", lat, 2);
    checkOutput("mac.nowr", sawWr, 1'b0);
    checkOutput("mac.nolearn", mem[8'h77], '0);

    applyStimulus(D1, S1, 2'd2, 32'd1000, -1, -1, lat, sawWr);
    checkOutput("empty.dport", bus.d_port, 5'b0_1011);
    checkOutput("empty.lat", lat, 7);
    checkOutput("empty.entry", mem[8'h02], entry(32'd1000, 2'd2, S1));

    applyStimulus(D1, AA, 2'd3, 32'd100, -1, -1, lat, sawWr);
    checkOutput("learnA.dport", bus.d_port, 5'b0_0111);
    applyStimulus(AA, CC, 2'd0, 32'd150, -1, -1, lat, sawWr);
    checkOutput("hit150.dport", bus.d_port, 5'b0_1000);
    applyStimulus(AA, CC, 2'd0, 32'd160, -1, -1, lat, sawWr);
    checkOutput("hitEdge.dport", bus.d_port, 5'b0_1000);
    checkOutput("relearn.reused", bus.reused, 1'b0);
    checkOutput("relearn.time", mem[8'h22], entry(32'd160, 2'd0, CC));
    applyStimulus(AA, CC, 2'd0, 32'd200, -1, -1, lat, sawWr);
    checkOutput("aged.dport", bus.d_port, 5'b0_1110);
    checkOutput("aged.time", mem[8'h22], entry(32'd200, 2'd0, CC));
    applyStimulus(AA, 48'h33, 2'd3, 32'd110, -1, -1, lat, sawWr);
    checkOutput("samePort.dport", bus.d_port, 5'b0_0000);

    bus.max_age = 32'd40;
    preload(8'h44, entry(32'hFFFF_FFF0, 2'd1, 48'h44));
    applyStimulus(48'h44, 48'h55, 2'd0, 32'h0000_0010, -1, -1, lat, sawWr);
    checkOutput("wrap.dport", bus.d_port, 5'b0_0010);

    applyStimulus(D1, A2, 2'd1, 32'd300, -1, -1, lat, sawWr);
    checkOutput("reuse0.reused", bus.reused, 1'b0);
    applyStimulus(D1, B2, 2'd2, 32'd310, 4, -1, lat, sawWr);
    checkOutput("reuse.reused", bus.reused, 1'b1);
    checkOutput("reuse.addr", bus.lst_inv_addr, A2);
    checkOutput("reuse.port", bus.lst_inv_port, 2'd1);
    @(negedge pclk);
    bus.clear_reused = 1'b1;
    @(negedge pclk);
    bus.clear_reused = 1'b0;
    checkOutput("clear.reused", bus.reused, 1'b0);
    checkOutput("clear.addrHeld", bus.lst_inv_addr, A2);

    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h88, 2'd1, 32'd400, -1, -1, lat, sawWr);
    checkOutput("bcast.dport", bus.d_port, 5'b0_1101);
    checkOutput("bcast.lat", lat, bcastLat);
    checkOutput("bcast.entry", mem[8'h88], entry(32'd400, 2'd1, 48'h88));

    applyStimulus(D1, 48'h1100, 2'd2, 32'd500, -1, 5, lat, sawWr);
    checkOutput("midwr.memwr", bus.mem_wr, 1'b1);
    checkOutput("midwr.reused", bus.reused, 1'b1);
    p_reset = 1'b1;
    #1;
    checkOutput("midrst.memwr", bus.mem_wr, 1'b0);
    checkOutput("midrst.busy", bus.busy, 1'b0);
    checkOutput("midrst.dport", bus.d_port, 5'b0_1111);
    checkOutput("midrst.reused", bus.reused, 1'b0);
    checkOutput("midrst.invaddr", bus.lst_inv_addr, 48'h0);
    @(negedge pclk);
    p_reset = 1'b0;
    applyStimulus(MAC, 48'h99, 2'd0, 32'd600, -1, -1, lat, sawWr);
    checkOutput("recover.lat", lat, 2);

    checkOutput("rdwr.exclusive", bothHigh, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
